commit_monitor: RTL

Consumer end of the core's commit stream (commit, commit_pc, commit_pre_pc, commit_branch, commit_taken). It reconstructs the actual control flow from consecutive retirements and detects next-PC mispredictions. It keeps saturating performance counters and buffers misprediction events in a small FIFO drained over a valid/ready port. It also flags a hung pipeline and misaligned commit PCs. It is instantiated beside the CPU in the simulation/FPGA top.

---
 rtl/commit_monitor.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/commit_monitor.sv
// commit_monitor
//   Watches the core's retirement stream and rebuilds the real control flow
//   from back-to-back commits. A commit whose PC differs from the next PC that
//   was predicted for the previous commit is a misprediction. That event is
//   counted and queued in a small trace FIFO, which a sink drains over a
//   valid/ready handshake. The block also keeps saturating retirement
//   statistics, and raises sticky flags for a hung pipeline and for misaligned
//   commit PCs.
//
// Ports
//   clk_i, rst         clock; synchronous active-high reset
//   commit_*_i         retirement stream (pc, predicted next pc, branch info)
//   trace_ready_i      sink accepts the head trace entry
//   trace_valid_o      trace FIFO non-empty
//   trace_*_pc_o       head entry: mispredicted pc, its prediction, actual next pc
//   *_cnt_o            saturating event counters
//   hang_o             sticky: no commit for TIMEOUT cycles while running
//   align_err_o        sticky: a commit pc had non-zero low bits
module commit_monitor #(
  parameter int PC_WIDTH   = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk_i,
  input  logic                rst,
  input  logic                commit_i,
  input  logic [PC_WIDTH-1:0] commit_pc_i,
  input  logic [PC_WIDTH-1:0] commit_pre_pc_i,
  input  logic                commit_branch_i,
  input  logic                commit_taken_i,
  input  logic                trace_ready_i,
  output logic                trace_valid_o,
  output logic [PC_WIDTH-1:0] trace_from_pc_o,
  output logic [PC_WIDTH-1:0] trace_pred_pc_o,
  output logic [PC_WIDTH-1:0] trace_act_pc_o,
  output logic [CNT_W-1:0]    commit_cnt_o,
  output logic [CNT_W-1:0]    branch_cnt_o,
  output logic [CNT_W-1:0]    taken_cnt_o,
  output logic [CNT_W-1:0]    mispred_cnt_o,
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic                hang_o,
  output logic                align_err_o
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HANG = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic [PC_WIDTH-1:0] prev_pre_q, prev_pre_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]    commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                hang_q, hang_d;
  logic                align_err_q, align_err_d;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [PC_WIDTH-1:0] from_mem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] from_mem_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] pred_mem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] pred_mem_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] act_mem_q  [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] act_mem_d  [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic mispred;
  logic push;
  logic drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && trace_ready_i;

  // The first commit after reset has no predecessor, so it is never checked.
  assign mispred    = commit_i && (state_q != ST_IDLE) && (commit_pc_i != prev_pre_q);

  // A simultaneous pop frees the slot that a push into a full FIFO needs.
  assign push       = mispred && (!fifo_full || pop);
  assign drop       = mispred && fifo_full && !pop;

  always_comb begin
    state_d       = state_q;
    prev_pc_d     = prev_pc_q;
    prev_pre_d    = prev_pre_q;
    idle_cnt_d    = idle_cnt_q;
    commit_cnt_d  = commit_cnt_q;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    hang_d        = hang_q;
    align_err_d   = align_err_q;

    if (commit_i) begin
      commit_cnt_d = sat_inc(commit_cnt_q);
      if (commit_branch_i) begin
        branch_cnt_d = sat_inc(branch_cnt_q);
        if (commit_taken_i) begin
          taken_cnt_d = sat_inc(taken_cnt_q);
        end
      end
      if (commit_pc_i[1:0] != 2'b00) begin
        align_err_d = 1'b1;
      end
      prev_pc_d  = commit_pc_i;
      prev_pre_d = commit_pre_pc_i;
      idle_cnt_d = '0;
      state_d    = ST_RUN;
    end else if (state_q == ST_RUN) begin
      // Idle cycles are only counted once the pipeline has retired something.
      if (idle_cnt_q == IDLE_LAST) begin
        hang_d  = 1'b1;
        state_d = ST_HANG;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end

    if (mispred) begin
      mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    from_mem_d = from_mem_q;
    pred_mem_d = pred_mem_q;
    act_mem_d  = act_mem_q;

    // The event belongs to the previous commit; the current PC is where
    // control actually went.
    if (push) begin
      from_mem_d[wr_ptr_q[PTR_W-1:0]] = prev_pc_q;
      pred_mem_d[wr_ptr_q[PTR_W-1:0]] = prev_pre_q;
      act_mem_d[wr_ptr_q[PTR_W-1:0]]  = commit_pc_i;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prev_pc_q     <= '0;
      prev_pre_q    <= '0;
      idle_cnt_q    <= '0;
      commit_cnt_q  <= '0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
      hang_q        <= 1'b0;
      align_err_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      from_mem_q    <= '{default: '0};
      pred_mem_q    <= '{default: '0};
      act_mem_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      prev_pc_q     <= prev_pc_d;
      prev_pre_q    <= prev_pre_d;
      idle_cnt_q    <= idle_cnt_d;
      commit_cnt_q  <= commit_cnt_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      hang_q        <= hang_d;
      align_err_q   <= align_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      from_mem_q    <= from_mem_d;
      pred_mem_q    <= pred_mem_d;
      act_mem_q     <= act_mem_d;
    end
  end

  // Head entry is read straight from storage so it holds while ready is low.
  assign trace_valid_o   = !fifo_empty;
  assign trace_from_pc_o = from_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign trace_pred_pc_o = pred_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign trace_act_pc_o  = act_mem_q[rd_ptr_q[PTR_W-1:0]];

  assign commit_cnt_o  = commit_cnt_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign taken_cnt_o   = taken_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign hang_o        = hang_q;
  assign align_err_o   = align_err_q;

endmodule
